// File: rtl/ram_pkg.sv
// Shared types and defaults for the sweep-clear RAM family.
// Imported by the interface, the clear sequencer and the top.
package ram_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  // Address width for a given depth; at least one bit so a 1-deep array still has a port.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_sweep_clr_if.sv
// Access bus of the sweep-clear RAM: request side driven by the master,
// read data and status strobes driven by the RAM.
interface ram_sweep_clr_if
  import ram_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = addr_w(DEF_DEPTH)
);

  logic              en;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_out;
  logic              rd_valid;
  logic              busy;
  logic              err;

  modport master (
    output en, rw, addr, data_in,
    input  data_out, rd_valid, busy, err
  );

  modport slave (
    input  en, rw, addr, data_in,
    output data_out, rd_valid, busy, err
  );

endinterface

// File: rtl/ram_clr_seq.sv
// Clear sequencer: after clr falls, steps a pointer over every word once,
// asserting we_sweep each step and busy until the last word is written.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  output logic              busy,
  output logic              we_sweep,
  output logic [ADDR_W-1:0] ptr
);

  state_e            state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic              last_w;

  assign last_w = (ptr_q == ADDR_W'(DEPTH - 1));
  // Pointer holds at the last word so it never wraps past DEPTH-1.
  assign ptr_d  = last_w ? ptr_q : ptr_q + ADDR_W'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
        end
        CLEAR: begin
          ptr_q <= ptr_d;
          if (last_w) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign we_sweep = (state_q == CLEAR) && !clr;
  assign ptr      = ptr_q;

endmodule

// File: rtl/ram_sweep_clr.sv
// Single-port synchronous RAM with registered read, optional write-through
// and a hardware clear sweep that loads RESET_VAL into every word after clr.
module ram_sweep_clr
  import ram_pkg::*;
#(
  parameter int                WIDTH         = DEF_WIDTH,
  parameter int                DEPTH         = DEF_DEPTH,
  parameter int                ADDR_W        = addr_w(DEPTH),
  parameter logic [WIDTH-1:0]  RESET_VAL     = '0,
  parameter bit                WRITE_THROUGH = 1'b0
) (
  input  logic         clk,
  input  logic         clr,
  ram_sweep_clr_if.slave bus
);

  localparam int CMP_W = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              busy;
  logic              we_sweep;
  logic [ADDR_W-1:0] ptr;

  logic              in_range;
  logic              accept;
  logic              acc_we;

  logic [WIDTH-1:0]  data_out_q;
  logic              rd_valid_q;
  logic              err_q;

  ram_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .clr      (clr),
    .busy     (busy),
    .we_sweep (we_sweep),
    .ptr      (ptr)
  );

  // Compare one bit wider so a power-of-two DEPTH does not truncate to zero.
  assign in_range = ({1'b0, bus.addr} < CMP_W'(DEPTH));
  assign accept   = bus.en && !busy && in_range;
  assign acc_we   = accept && bus.rw && !clr;

  // NOTE: the array has no reset branch; its contents are defined by the
  // clear sweep, which keeps it mappable onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (we_sweep) begin
      mem[ptr] <= RESET_VAL;
    end else if (acc_we) begin
      mem[bus.addr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      err_q      <= bus.en && !accept;
      if (accept) begin
        if (!bus.rw) begin
          data_out_q <= mem[bus.addr];
          rd_valid_q <= 1'b1;
        end else if (WRITE_THROUGH) begin
          data_out_q <= bus.data_in;
          rd_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_ram_sweep_clr.sv
// Directed bench for ram_sweep_clr: three instances (4-deep, 5-deep,
// 4-deep write-through with RESET_VAL 9) share clk, clr and the request fields.
module tb_ram_sweep_clr;

  logic       clk = 1'b0;
  logic       clr;
  logic [2:0] en_v;
  logic       rw;
  logic [2:0] addr;
  logic [3:0] din;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_sweep_clr_if #(.WIDTH(4), .ADDR_W(2)) if4 ();
  ram_sweep_clr_if #(.WIDTH(4), .ADDR_W(3)) if5 ();
  ram_sweep_clr_if #(.WIDTH(4), .ADDR_W(2)) ifw ();

  assign if4.en = en_v[0];
  assign if4.rw = rw;
  assign if4.addr = addr[1:0];
  assign if4.data_in = din;
  assign if5.en = en_v[1];
  assign if5.rw = rw;
  assign if5.addr = addr;
  assign if5.data_in = din;
  assign ifw.en = en_v[2];
  assign ifw.rw = rw;
  assign ifw.addr = addr[1:0];
  assign ifw.data_in = din;

  ram_sweep_clr #(.WIDTH(4), .DEPTH(4)) u_d4 (
    .clk (clk), .clr (clr), .bus (if4.slave)
  );
  ram_sweep_clr #(.WIDTH(4), .DEPTH(5)) u_d5 (
    .clk (clk), .clr (clr), .bus (if5.slave)
  );
  ram_sweep_clr #(.WIDTH(4), .DEPTH(4), .RESET_VAL(4'h9), .WRITE_THROUGH(1'b1)) u_wt (
    .clk (clk), .clr (clr), .bus (ifw.slave)
  );

  function automatic logic [3:0] dout(input int s);
    case (s)
      0:       return if4.data_out;
      1:       return if5.data_out;
      default: return ifw.data_out;
    endcase
  endfunction

  function automatic logic rv(input int s);
    case (s)
      0:       return if4.rd_valid;
      1:       return if5.rd_valid;
      default: return ifw.rd_valid;
    endcase
  endfunction

  function automatic logic er(input int s);
    case (s)
      0:       return if4.err;
      1:       return if5.err;
      default: return ifw.err;
    endcase
  endfunction

  function automatic logic bz(input int s);
    case (s)
      0:       return if4.busy;
      1:       return if5.busy;
      default: return ifw.busy;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int s, input logic w, input logic [2:0] a, input logic [3:0] d);
    en_v    = '0;
    en_v[s] = 1'b1;
    rw      = w;
    addr    = a;
    din     = d;
    step();
    en_v    = '0;
  endtask

  // Samples busy once per cycle starting right after the last clr edge.
  task automatic count_busy(output int c0, output int c1, output int c2);
    c0 = 0;
    c1 = 0;
    c2 = 0;
    for (int i = 0; i < 12; i++) begin
      if (bz(0)) c0++;
      if (bz(1)) c1++;
      if (bz(2)) c2++;
      step();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bz(0) || bz(1) || bz(2)) && n < 20) begin
      step();
      n++;
    end
    check("sweep_done_in_time", {31'd0, bz(0) | bz(1) | bz(2)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2;
    clr  = 1'b1;
    en_v = '0;
    rw   = 1'b0;
    addr = '0;
    din  = '0;

    // Reset sweep
    step();
    step();
    check("clr_busy", {31'd0, bz(0)}, 32'd1);
    check("clr_dout", {28'd0, dout(0)}, 32'd0);
    check("clr_rv", {31'd0, rv(0)}, 32'd0);
    check("clr_err", {31'd0, er(0)}, 32'd0);
    clr = 1'b0;
    count_busy(c0, c1, c2);
    check("sweep_len_d4", c0, 32'd4);
    check("sweep_len_d5", c1, 32'd5);
    check("sweep_len_wt", c2, 32'd4);
    for (int a = 0; a < 4; a++) begin
      access(0, 1'b0, 3'(a), 4'h0);
      check("rd_clr_rv", {31'd0, rv(0)}, 32'd1);
      check("rd_clr_dout", {28'd0, dout(0)}, 32'd0);
    end
    step();
    check("rv_single_pulse", {31'd0, rv(0)}, 32'd0);

    // Write / read
    access(0, 1'b1, 3'd0, 4'hA);
    check("wr_no_rv", {31'd0, rv(0)}, 32'd0);
    check("wr_no_err", {31'd0, er(0)}, 32'd0);
    check("wr_dout_held", {28'd0, dout(0)}, 32'd0);
    access(0, 1'b1, 3'd3, 4'h5);
    access(0, 1'b0, 3'd3, 4'h0);
    check("rd3_dout", {28'd0, dout(0)}, 32'h5);
    check("rd3_rv", {31'd0, rv(0)}, 32'd1);
    access(0, 1'b0, 3'd0, 4'h0);
    check("rd0_dout", {28'd0, dout(0)}, 32'hA);
    check("rd0_rv", {31'd0, rv(0)}, 32'd1);
    step();
    check("idle_rv", {31'd0, rv(0)}, 32'd0);
    check("idle_err", {31'd0, er(0)}, 32'd0);
    check("idle_dout_hold", {28'd0, dout(0)}, 32'hA);
    access(0, 1'b1, 3'd2, 4'h6);
    access(0, 1'b0, 3'd2, 4'h0);
    check("b2b_rd_new", {28'd0, dout(0)}, 32'h6);

    // Access during sweep
    access(0, 1'b1, 3'd1, 4'h3);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    access(0, 1'b1, 3'd1, 4'hF);
    check("busy_wr_err", {31'd0, er(0)}, 32'd1);
    check("busy_wr_rv", {31'd0, rv(0)}, 32'd0);
    check("busy_wr_dout", {28'd0, dout(0)}, 32'd0);
    step();
    check("busy_err_pulse", {31'd0, er(0)}, 32'd0);
    wait_idle();
    access(0, 1'b0, 3'd1, 4'h0);
    check("rd1_after_sweep", {28'd0, dout(0)}, 32'h0);
    check("rd1_after_sweep_rv", {31'd0, rv(0)}, 32'd1);

    // clr mid-sweep
    access(0, 1'b1, 3'd0, 4'h4);
    access(0, 1'b0, 3'd0, 4'h0);
    check("pre_mid_dout", {28'd0, dout(0)}, 32'h4);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    step();
    clr = 1'b1;
    step();
    check("mid_clr_busy", {31'd0, bz(0)}, 32'd1);
    check("mid_clr_dout", {28'd0, dout(0)}, 32'd0);
    clr = 1'b0;
    count_busy(c0, c1, c2);
    check("mid_sweep_len_d4", c0, 32'd4);
    check("mid_sweep_dout", {28'd0, dout(0)}, 32'd0);
    access(0, 1'b0, 3'd0, 4'h0);
    check("mid_rd0", {28'd0, dout(0)}, 32'h0);

    // Out of range, DEPTH=5
    for (int i = 0; i < 5; i++) access(1, 1'b1, 3'(i), 4'(i + 1));
    access(1, 1'b1, 3'd6, 4'h7);
    check("oor_wr_err", {31'd0, er(1)}, 32'd1);
    step();
    check("oor_err_pulse", {31'd0, er(1)}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      access(1, 1'b0, 3'(i), 4'h0);
      check("d5_rd_dout", {28'd0, dout(1)}, 32'(i + 1));
      check("d5_rd_err", {31'd0, er(1)}, 32'd0);
    end
    access(1, 1'b0, 3'd7, 4'h0);
    check("oor_rd_err", {31'd0, er(1)}, 32'd1);
    check("oor_rd_rv", {31'd0, rv(1)}, 32'd0);
    check("oor_rd_dout", {28'd0, dout(1)}, 32'h5);
    access(1, 1'b0, 3'd5, 4'h0);
    check("oor_rd5_err", {31'd0, er(1)}, 32'd1);

    // Write-through, RESET_VAL=9
    access(2, 1'b0, 3'd2, 4'h0);
    check("wt_rd_reset", {28'd0, dout(2)}, 32'h9);
    access(2, 1'b1, 3'd2, 4'hC);
    check("wt_wr_dout", {28'd0, dout(2)}, 32'hC);
    check("wt_wr_rv", {31'd0, rv(2)}, 32'd1);
    access(2, 1'b0, 3'd0, 4'h0);
    check("wt_rd0_reset", {28'd0, dout(2)}, 32'h9);
    access(2, 1'b0, 3'd2, 4'h0);
    check("wt_rd2_new", {28'd0, dout(2)}, 32'hC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sweep_clr.md
Name: ram_sweep_clr

Overview:
- Parametrised single-port synchronous RAM, WIDTH x DEPTH; next generation of the fixed 2x4 word-select RAM.
- Registered read with a one-cycle valid strobe and optional write-through.
- Hardware clear sequencer writes RESET_VAL into every word after clr, reporting busy meanwhile.
- Sits as the general storage primitive under register files and scratchpads.

Parameters:
- WIDTH, 4: bits per word.
- DEPTH, 4: number of words, >=2, need not be a power of two.
- ADDR_W, $clog2(DEPTH): address width.
- RESET_VAL, 0: word value written by the clear sweep.
- WRITE_THROUGH, 0: if 1, a write also drives data_out and pulses rd_valid.

Ports:
- clk  in  1  clock, all state on rising edge.
- clr  in  1  reset, synchronous, active-high; starts the clear sweep.
- en  in  1  access request, sampled each edge.
- rw  in  1  1 = write, 0 = read; qualified by en.
- addr  in  ADDR_W  word address.
- data_in  in  WIDTH  write data.
- data_out  out  WIDTH  registered read data; holds between reads.
- rd_valid  out  1  one-cycle strobe: data_out updated this cycle.
- busy  out  1  clear sweep in progress; accesses ignored.
- err  out  1  one-cycle strobe: access ignored (busy or addr >= DEPTH).

Behaviour:
- States: IDLE, CLEAR. Sweep pointer ptr is ADDR_W bits.
- Edge with clr=1, from any state including mid-sweep:
  - state<=CLEAR, ptr<=0.
  - data_out<=0, rd_valid<=0, err<=0, busy<=1.
  - Memory is not written while clr stays high.
- CLEAR with clr=0:
  - Each edge writes mem[ptr]<=RESET_VAL and increments ptr.
  - On the edge that writes ptr==DEPTH-1: state<=IDLE, busy<=0.
  - busy is therefore high for exactly DEPTH edges after clr falls.
  - First accepted access is on the next edge after busy clears.
- Access while busy (en=1): no memory change, data_out unchanged, rd_valid=0, err=1 for one cycle. Requests are not queued.
- IDLE read (en=1, rw=0, addr<DEPTH):
  - Edge N: data_out<=mem[addr], rd_valid=1 during cycle N+1 only.
  - Latency is 1 edge.
- IDLE write (en=1, rw=1, addr<DEPTH):
  - Edge N: mem[addr]<=data_in.
  - WRITE_THROUGH=0: data_out unchanged, rd_valid=0.
  - WRITE_THROUGH=1: data_out<=data_in, rd_valid=1.
- Read of an address written on the previous edge returns the new data.
- addr >= DEPTH (non-power-of-two DEPTH only):
  - Read: data_out unchanged, rd_valid=0.
  - Write: no memory change.
  - Both: err=1 for one cycle.
- en=0: no change; rd_valid=0, err=0 next cycle.
- Power-up memory contents are undefined until the first completed sweep. The bench must assert clr before use.
- Widths: data is never truncated or extended. ptr increments only below DEPTH-1, so it never wraps.

Decomposition:
- Shared package ram_pkg:
  - state enum {IDLE, CLEAR}.
  - Constant-function helper for ADDR_W.
  - Default WIDTH/DEPTH localparams.
- Sub-module ram_clr_seq (clk, clr → busy, we_sweep, ptr): owns the FSM and ptr.
- Top holds the memory array, access muxing (sweep write has priority), and output registers.

Test Plan:
- Reset sweep, WIDTH=4, DEPTH=4:
  - clr high 2 cycles then low → busy high exactly 4 edges.
  - Then read addr 0..3 → data_out=0, rd_valid pulse each read.
- Write/read:
  - Write 4'hA @0, 4'h5 @3; read 3 then 0.
  - → data_out=4'h5 then 4'hA, 1-cycle latency, rd_valid single-cycle pulses.
  - Write then read same addr back-to-back → new value.
- Access during sweep:
  - Write 4'hF @1 on the second busy cycle → err=1, ignored.
  - Read 1 after sweep → 4'h0 (RESET_VAL).
- clr mid-sweep:
  - Reassert clr at sweep step 2 → ptr restarts.
  - busy stays high 4 edges after the new clr fall; data_out=0.
- Out of range, DEPTH=5, ADDR_W=3:
  - Write 4'h7 @6 → err pulse.
  - Reads of 0..4 unchanged; read @7 → err, rd_valid=0.
- WRITE_THROUGH=1, RESET_VAL=4'h9:
  - After sweep, read 2 → 4'h9.
  - Write 4'hC @2 → data_out=4'hC, rd_valid=1 on the next cycle.
